keycode_fifo_pio: RTL and testbench
===================================

KEYCODE_FIFO_PIO -- requirements
Module: keycode_fifo_pio

Interface
REQ-001 SHALL have parameter DATA_W, default 8: keycode width in bits, range 1..32.
REQ-002 SHALL have parameter DEPTH, default 8: FIFO entries, power of 2, range 2..64.
REQ-003 SHALL have port clk, input, 1 bit: clock.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have ports address (in, 2), chipselect (in, 1), write_n (in, 1), writedata (in, 32) and readdata (out, 32), forming an Avalon-MM slave with zero wait states.
REQ-006 SHALL have ports out_data (out, DATA_W), out_valid (out, 1) and out_ready (in, 1), forming the game-logic consumer stream.
REQ-007 SHALL have port out_port, output, DATA_W bits: last keycode popped, held until the next pop.
REQ-008 SHALL have port irq, output, 1 bit: level interrupt; tied to 0 when the feature is excluded.

Function
REQ-009 SHALL decode the register map as: 0 = DATA, 1 = STATUS, 2 = CONTROL, 3 = reserved (reads 0, writes ignored).
REQ-010 SHALL push writedata[DATA_W-1:0] on a write to DATA (chipselect && !write_n && address==0).
REQ-011 SHALL return the FIFO head zero-extended on a DATA read, with no pop and 0 when empty.
REQ-012 SHALL return STATUS as: [7:0] count, [8] empty, [9] full, [10] overflow (sticky), [11] irq pending; all other bits 0.
REQ-013 SHALL clear overflow on a STATUS write with writedata[10]=1.
REQ-014 SHALL use CONTROL bit 0 for flush (self-clearing, reads 0) and bit 1 for irq_en (read/write); bits [15:8] SHALL hold low-water threshold LWM.
REQ-015 SHALL present readdata combinationally from address in the same cycle.
REQ-016 SHALL drive out_valid = !empty and out_data = head; a pop occurs when out_valid && out_ready.
REQ-017 SHALL register out_port <= head on a pop, giving 1-cycle latency.
REQ-018 SHALL accept a push while full if a pop occurs in the same cycle; count stays DEPTH.
REQ-019 SHALL drop a push while full without a pop, leave contents unchanged and set overflow.
REQ-020 SHALL update count by +1, -1 or 0 on push only, pop only, or both (or neither).
REQ-021 SHALL, on flush, reset pointers and count to 0 in the next cycle; a same-cycle push and pop are ignored, overflow is unchanged and out_port holds.
REQ-022 SHALL wrap the read and write pointers modulo DEPTH, with count width $clog2(DEPTH)+1.
REQ-023 SHALL have out_valid, full, empty and count reflect the push/pop of cycle N in cycle N+1.

Reset
REQ-024 SHALL, on reset_n low, asynchronously set count=0, pointers=0, overflow=0, irq_en=0, LWM=0, out_port=0, irq=0, out_valid=0, and SHALL leave FIFO storage uninitialised.
REQ-025 SHALL release reset synchronously and discard any transfer in progress at reset.

Configuration
REQ-026 SHALL, with macro KEYCODE_FIFO_IRQ_EN defined, register irq = irq_en && (overflow || count <= LWM) and update it one cycle after its inputs change.
REQ-027 SHALL, without KEYCODE_FIFO_IRQ_EN, tie irq to 0, read STATUS[11] and CONTROL[1] as 0 and ignore writes to them; LWM stays readable and writable.

Structure
REQ-028 SHALL place register address constants, STATUS/CONTROL bit positions and the count-width function in shared package keycode_pio_pkg.
REQ-029 SHALL instantiate one sub-module, keycode_sync_fifo (storage, pointers, count, full/empty), with the Avalon decode kept in the top level.

Verification
REQ-030 Reset, then write DATA 0x1C, 0x1D, 0x23 -> STATUS count=3; out_data=0x1C with out_valid=1; after 3 pops out_port=0x23 and empty=1.
REQ-031 With DEPTH=8, write 9 keycodes with out_ready=0 -> full=1, overflow=1, the 9th dropped; write STATUS 0x400 -> overflow=0.
REQ-032 With full FIFO and out_ready=1, write 0x2A in the same cycle -> count stays 8; 0x2A is popped 8th.
REQ-033 With count=5, write CONTROL flush while pushing 0x11 -> next cycle count=0 and empty=1; 0x11 is never output.
REQ-034 With KEYCODE_FIFO_IRQ_EN defined, irq_en=1 and LWM=2, pop from 3 to 2 -> irq=1 one cycle later; push to 3 -> irq=0.
REQ-035 Assert reset_n mid-stream with count=4 -> outputs match REQ-024 immediately (asynchronously), with no glitch pop after release.

Source files
------------

// File: rtl/keycode_pio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : keycode_pio_pkg
// Purpose  : Shared definitions for the keycode FIFO PIO block: Avalon
//            register addresses, STATUS/CONTROL field positions and the
//            FIFO count-width helper.
// Ports    : none (package)
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
package keycode_pio_pkg;

   // Register map (word addresses on the 2-bit Avalon address bus)
   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_STATUS  = 2'd1;
   localparam logic [1:0] ADDR_CONTROL = 2'd2;
   localparam logic [1:0] ADDR_RSVD    = 2'd3;

   // STATUS fields
   localparam int STAT_COUNT_MSB = 7;
   localparam int STAT_EMPTY_BIT = 8;
   localparam int STAT_FULL_BIT  = 9;
   localparam int STAT_OVF_BIT   = 10;
   localparam int STAT_IRQ_BIT   = 11;

   // CONTROL fields
   localparam int CTRL_FLUSH_BIT = 0;
   localparam int CTRL_IRQEN_BIT = 1;
   localparam int CTRL_LWM_LSB   = 8;
   localparam int CTRL_LWM_MSB   = 15;

   // Count must represent 0..DEPTH inclusive, hence one bit more than the pointer.
   function automatic int count_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage : keycode_pio_pkg
`default_nettype wire

// File: rtl/keycode_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : keycode_sync_fifo
// Purpose  : Single-clock FIFO holding keycodes: storage, read/write
//            pointers, occupancy count and full/empty flags.
// Ports    : clk, rst_n (async active-low)
//            flush           - clear pointers/count; overrides push and pop
//            push, wdata     - write request and data (dropped when full
//                              unless a pop happens in the same cycle)
//            pop             - read request (ignored when empty)
//            head            - entry at the read pointer
//            count/empty/full- occupancy, registered
// Config   : none
// Revision : 1.0 - initial release
// ============================================================================
module keycode_sync_fifo
   import keycode_pio_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8,
   parameter int CW     = count_width(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] wdata,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic [CW-1:0]     count,
   output logic              empty,
   output logic              full
);

   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q,  count_d;
   logic              pop_ok;
   logic              push_ok;

   assign empty  = (count_q == '0);
   assign full   = (count_q == CW'(DEPTH));
   assign pop_ok = pop && !empty;
   // A full FIFO still accepts a push when an entry leaves in the same cycle.
   assign push_ok = push && (!full || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // DEPTH is a power of two, so the natural pointer rollover is the wrap.
         if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; contents are only meaningful below count.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[wr_ptr_q] <= wdata;
   end

   assign head  = mem[rd_ptr_q];
   assign count = count_q;

endmodule : keycode_sync_fifo
`default_nettype wire

// File: rtl/keycode_fifo_pio.sv
`default_nettype none
// ============================================================================
// Module   : keycode_fifo_pio
// Purpose  : Keycode FIFO with an Avalon-MM slave front end (zero wait
//            states) and a ready/valid stream towards the game logic.
// Ports    : clk, reset_n (async assert, synchronised release)
//            address/chipselect/write_n/writedata/readdata - Avalon slave
//            out_data/out_valid/out_ready - consumer stream
//            out_port - last keycode popped, held until the next pop
//            irq      - level interrupt
// Config   : KEYCODE_FIFO_IRQ_EN - when defined, irq = irq_en &&
//            (overflow || count <= LWM), registered. When undefined, irq is
//            0 and STATUS[11]/CONTROL[1] read 0.
// Revision : 1.0 - initial release
// ============================================================================
module keycode_fifo_pio
   import keycode_pio_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_port,
   output logic              irq
);

   localparam int CW = count_width(DEPTH);

   // Reset asserts immediately but releases on a clock edge, so no flop sees
   // a partial deassertion and any bus cycle overlapping reset is discarded.
   logic [1:0] rst_sync_q;
   logic       rst_n;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rst_sync_q <= 2'b00;
      else          rst_sync_q <= {rst_sync_q[0], 1'b1};
   end
   assign rst_n = rst_sync_q[1];

   logic              wr_en, push, pop, flush;
   logic [DATA_W-1:0] head;
   logic [CW-1:0]     count;
   logic              empty, full;
   logic [7:0]        count8;

   logic              overflow_q, overflow_d;
   logic [7:0]        lwm_q, lwm_d;
   logic [DATA_W-1:0] out_port_q, out_port_d;
   logic              irq_en;
   logic              irq_pend;

   assign wr_en  = chipselect && !write_n;
   assign push   = wr_en && (address == ADDR_DATA);
   assign flush  = wr_en && (address == ADDR_CONTROL) && writedata[CTRL_FLUSH_BIT];
   assign pop    = out_valid && out_ready;
   assign count8 = 8'(count);

   keycode_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .CW     (CW)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push),
      .wdata (writedata[DATA_W-1:0]),
      .pop   (pop),
      .head  (head),
      .count (count),
      .empty (empty),
      .full  (full)
   );

   always_comb begin
      overflow_d = overflow_q;
      lwm_d      = lwm_q;
      out_port_d = out_port_q;
      if (wr_en && (address == ADDR_STATUS) && writedata[STAT_OVF_BIT])
         overflow_d = 1'b0;
      // A dropped push takes priority over a same-cycle clear so it is never lost.
      if (push && full && !pop && !flush)
         overflow_d = 1'b1;
      if (wr_en && (address == ADDR_CONTROL))
         lwm_d = writedata[CTRL_LWM_MSB:CTRL_LWM_LSB];
      // A pop coinciding with flush is cancelled, so out_port holds.
      if (pop && !flush)
         out_port_d = head;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q <= 1'b0;
         lwm_q      <= 8'd0;
         out_port_q <= '0;
      end else begin
         overflow_q <= overflow_d;
         lwm_q      <= lwm_d;
         out_port_q <= out_port_d;
      end
   end

`ifdef KEYCODE_FIFO_IRQ_EN
   logic irq_en_q, irq_en_d;
   logic irq_q,    irq_d;

   always_comb begin
      irq_en_d = irq_en_q;
      if (wr_en && (address == ADDR_CONTROL))
         irq_en_d = writedata[CTRL_IRQEN_BIT];
      irq_d = irq_en_q && (overflow_q || (count8 <= lwm_q));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
         irq_q    <= irq_d;
      end
   end

   assign irq_en   = irq_en_q;
   assign irq_pend = irq_q;
`else
   assign irq_en   = 1'b0;
   assign irq_pend = 1'b0;
`endif

   assign irq       = irq_pend;
   assign out_valid = !empty;
   assign out_data  = head;
   assign out_port  = out_port_q;

   always_comb begin
      readdata = 32'd0;
      case (address)
         ADDR_DATA: begin
            if (!empty) readdata = 32'(head);
         end
         ADDR_STATUS: begin
            readdata[STAT_COUNT_MSB:0] = count8;
            readdata[STAT_EMPTY_BIT]   = empty;
            readdata[STAT_FULL_BIT]    = full;
            readdata[STAT_OVF_BIT]     = overflow_q;
            readdata[STAT_IRQ_BIT]     = irq_pend;
         end
         ADDR_CONTROL: begin
            readdata[CTRL_IRQEN_BIT]             = irq_en;
            readdata[CTRL_LWM_MSB:CTRL_LWM_LSB]  = lwm_q;
         end
         default: readdata = 32'd0;
      endcase
   end

   // Not every writedata bit is a register field.
   logic unused_wd;
   assign unused_wd = ^writedata;

endmodule : keycode_fifo_pio
`default_nettype wire

// File: tb/tb_keycode_fifo_pio.sv
`default_nettype none
// ============================================================================
// Module   : tb_keycode_fifo_pio
// Purpose  : Directed self-checking bench for keycode_fifo_pio (default
//            parameters DATA_W=8, DEPTH=8). Honours KEYCODE_FIFO_IRQ_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keycode_fifo_pio;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_port;
   logic        irq;

   int vectors    = 0;
   int miscompares = 0;
   logic [31:0] rd_val;

   always #5 clk = ~clk;

   keycode_fifo_pio #(.DATA_W(8), .DEPTH(8)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_port   (out_port),
      .irq        (irq)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic av_write(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      tick();
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
   endtask

   task automatic av_read(input logic [1:0] a, output logic [31:0] d);
      address    = a;
      chipselect = 1'b1;
      write_n    = 1'b1;
      #1;
      d          = readdata;
      chipselect = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset_n    = 1'b0;
      address    = 2'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'd0;
      out_ready  = 1'b0;
      repeat (2) tick();

      // Reset state
      check("rst_out_valid", 32'(out_valid), 32'h0);
      check("rst_out_port",  32'(out_port),  32'h0);
      check("rst_irq",       32'(irq),       32'h0);
      av_read(2'd1, rd_val);
      check("rst_status",    rd_val,         32'h100);

      reset_n = 1'b1;
      repeat (3) tick();

      // Basic push / head / pop
      av_write(2'd0, 32'h1C);
      av_write(2'd0, 32'h1D);
      av_write(2'd0, 32'h23);
      av_read(2'd1, rd_val);
      check("b_status3",   rd_val,          32'h003);
      check("b_out_valid", 32'(out_valid),  32'h1);
      check("b_out_data",  32'(out_data),   32'h1C);
      av_read(2'd0, rd_val);
      check("b_data_read", rd_val,          32'h1C);
      av_read(2'd1, rd_val);
      check("b_read_nopop", rd_val,         32'h003);
      av_read(2'd3, rd_val);
      check("b_reserved",  rd_val,          32'h0);
      out_ready = 1'b1;
      tick();
      check("b_port_first", 32'(out_port),  32'h1C);
      tick();
      tick();
      out_ready = 1'b0;
      check("b_port_last", 32'(out_port),   32'h23);
      check("b_valid_0",   32'(out_valid),  32'h0);
      av_read(2'd1, rd_val);
      check("b_empty",     rd_val,          32'h100);
      av_read(2'd0, rd_val);
      check("b_data_empty", rd_val,         32'h0);

      // Fill and overflow
      for (int i = 0; i < 8; i++) av_write(2'd0, 32'h30 + i);
      av_read(2'd1, rd_val);
      check("o_full",      rd_val,          32'h208);
      av_write(2'd0, 32'h38);
      av_read(2'd1, rd_val);
      check("o_overflow",  rd_val,          32'h608);
      check("o_head_kept", 32'(out_data),   32'h30);
      av_write(2'd1, 32'h400);
      av_read(2'd1, rd_val);
      check("o_ovf_clear", rd_val,          32'h208);

      // Push while full with a same-cycle pop
      out_ready = 1'b1;
      av_write(2'd0, 32'h2A);
      out_ready = 1'b0;
      av_read(2'd1, rd_val);
      check("pf_count8",   rd_val,          32'h208);
      check("pf_port",     32'(out_port),   32'h30);
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("pf_order", 32'(out_data), (i < 7) ? (32'h31 + i) : 32'h2A);
         tick();
      end
      out_ready = 1'b0;
      check("pf_port_8th", 32'(out_port),   32'h2A);
      av_read(2'd1, rd_val);
      check("pf_empty",    rd_val,          32'h100);

      // Flush with a same-cycle pop attempt
      av_write(2'd0, 32'h41);
      av_write(2'd0, 32'h42);
      av_write(2'd0, 32'h43);
      av_write(2'd0, 32'h44);
      av_write(2'd0, 32'h11);
      av_read(2'd1, rd_val);
      check("f_count5",    rd_val,          32'h005);
      out_ready = 1'b1;
      av_write(2'd2, 32'h1);
      av_read(2'd1, rd_val);
      check("f_status",    rd_val,          32'h100);
      check("f_port_hold", 32'(out_port),   32'h2A);
      check("f_valid",     32'(out_valid),  32'h0);
      tick();
      out_ready = 1'b0;
      check("f_no_11",     32'(out_port),   32'h2A);
      av_read(2'd2, rd_val);
      check("f_ctrl_sc",   rd_val,          32'h0);

      // CONTROL readback
      av_write(2'd2, 32'h302);
`ifdef KEYCODE_FIFO_IRQ_EN
      av_read(2'd2, rd_val);
      check("c_ctrl",      rd_val,          32'h302);

      // Low-water interrupt
      av_write(2'd2, 32'h202);
      av_write(2'd0, 32'h51);
      av_write(2'd0, 32'h52);
      av_write(2'd0, 32'h53);
      tick();
      check("i_irq_c3",    32'(irq),        32'h0);
      av_read(2'd1, rd_val);
      check("i_status3",   rd_val,          32'h003);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("i_irq_lag",   32'(irq),        32'h0);
      tick();
      check("i_irq_c2",    32'(irq),        32'h1);
      av_read(2'd1, rd_val);
      check("i_status2",   rd_val,          32'h802);
      av_write(2'd0, 32'h54);
      check("i_irq_lag2",  32'(irq),        32'h1);
      tick();
      check("i_irq_off",   32'(irq),        32'h0);
`else
      av_read(2'd2, rd_val);
      check("c_ctrl",      rd_val,          32'h300);

      // Interrupt excluded: stays low even when enabled and below LWM
      av_write(2'd2, 32'h202);
      av_write(2'd0, 32'h51);
      av_write(2'd0, 32'h52);
      av_write(2'd0, 32'h53);
      tick();
      tick();
      check("i_irq_tied",  32'(irq),        32'h0);
      av_read(2'd1, rd_val);
      check("i_status3",   rd_val,          32'h003);
`endif

      // Asynchronous reset mid-stream
      av_write(2'd2, 32'h1);
      av_write(2'd0, 32'h61);
      av_write(2'd0, 32'h62);
      av_write(2'd0, 32'h63);
      av_write(2'd0, 32'h64);
      av_write(2'd2, 32'h0500);
      av_read(2'd1, rd_val);
      check("r_count4",    rd_val,          32'h004);
      check("r_head",      32'(out_data),   32'h61);
      out_ready = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      check("r_valid",     32'(out_valid),  32'h0);
      check("r_port",      32'(out_port),   32'h0);
      check("r_irq",       32'(irq),        32'h0);
      av_read(2'd1, rd_val);
      check("r_status",    rd_val,          32'h100);
      av_read(2'd2, rd_val);
      check("r_ctrl",      rd_val,          32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      repeat (4) tick();
      check("r_no_glitch", 32'(out_port),   32'h0);
      check("r_valid_rel", 32'(out_valid),  32'h0);
      av_read(2'd1, rd_val);
      check("r_status_rel", rd_val,         32'h100);
      out_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_keycode_fifo_pio
`default_nettype wire
